// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one fixed-latency single-ported memory between instruction fetch and data ports.
// Serialises accesses, holds each command for MEM_LATENCY cycles and returns registered data.
module unified_mem_arbiter #(
    parameter int unsigned MEM_LATENCY = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_data_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    localparam logic [3:0] CntInit = 4'(MEM_LATENCY - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q;
    logic              last_grant_q;
    logic              owner_q;
    logic              cmd_we_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [DATA_W-1:0] cmd_wdata_q;
    logic [DATA_W-1:0] if_data_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              any_req;
    logic              grant_d;

    assign any_req = if_req_i | d_req_i;
    // Owner encoding 1 = data port; a tie goes to the port that was not served last.
    assign grant_d = d_req_i & (~if_req_i | ~last_grant_q);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req) state_d = StBusy;
            StBusy:  if (cnt_q == 4'd0) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b0;
            owner_q      <= 1'b0;
            cmd_we_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            if_data_q    <= '0;
            d_rdata_q    <= '0;
        end else if (state_q == StIdle && any_req) begin
            owner_q     <= grant_d;
            cmd_we_q    <= grant_d & d_we_i;
            cmd_addr_q  <= grant_d ? d_addr_i : if_addr_i;
            cmd_wdata_q <= grant_d ? d_wdata_i : '0;
            cnt_q       <= CntInit;
        end else if (state_q == StBusy) begin
            if (cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end else begin
                last_grant_q <= owner_q;
                if (!cmd_we_q) begin
                    if (owner_q) d_rdata_q <= mem_rdata_i;
                    else         if_data_q <= mem_rdata_i;
                end
            end
        end
    end

    always_comb begin
        mem_req_o   = (state_q == StBusy);
        mem_we_o    = (state_q == StBusy) & cmd_we_q;
        mem_addr_o  = cmd_addr_q;
        mem_wdata_o = cmd_wdata_q;
        if_ack_o    = (state_q == StResp) & ~owner_q;
        d_ack_o     = (state_q == StResp) & owner_q;
        if_data_o   = if_data_q;
        d_rdata_o   = d_rdata_q;
        stall_o     = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o);
    end

endmodule
